// File: rtl/gpio_mmio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_mmio_pkg
// Purpose : Shared address map and decode helpers for the memory-mapped GPIO
//           peripheral. Offsets are byte addresses within the peripheral's
//           256-byte window. Each channel register is one 32-bit word.
// Contents: register base offsets, maximum channel count, and small helpers
//           that split a byte address into region and channel fields.
// ---------------------------------------------------------------------------
package gpio_mmio_pkg;

    localparam logic [7:0] GPI_BASE = 8'h00;
    localparam logic [7:0] GPO_BASE = 8'h20;
    localparam logic [7:0] SET_BASE = 8'h40;
    localparam logic [7:0] CLR_BASE = 8'h60;
    localparam logic [7:0] STATUS   = 8'h80;
    localparam logic [7:0] IRQ_EN   = 8'h84;

    localparam int MAX_CH = 8;

    // Each 32-byte region holds up to MAX_CH word registers
    function automatic logic [2:0] region_of(input logic [7:0] a);
        return a[7:5];
    endfunction

    function automatic logic [2:0] chan_of(input logic [7:0] a);
        return a[4:2];
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// ---------------------------------------------------------------------------
// gpio_sync
// Purpose : Multi-flop synchroniser for a bus of asynchronous input pins.
//           Each bit is treated independently. No attempt is made to keep
//           a multi-bit value coherent across bits.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-low reset (all stages cleared)
//           d    - asynchronous input bits
//           q    - synchronised output, STAGES edges after d
// ---------------------------------------------------------------------------
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) ff[k] <= '0;
        end else begin
            ff[0] <= d;
            for (int k = 1; k < STAGES; k++) ff[k] <= ff[k-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/gpio_mmio.sv
// ---------------------------------------------------------------------------
// gpio_mmio
// Purpose : Memory-mapped GPIO peripheral on the data-memory bus. It provides
//           N_IN synchronised input channels with per-channel change
//           detection, sticky write-1-to-clear status and a level interrupt.
//           It also provides N_OUT output channels with write, atomic set and
//           atomic clear access.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-low reset
//           sel  - bus access targets this block
//           we   - write strobe (qualified by sel)
//           addr - byte address, addr[1:0] ignored
//           wd   - write data
//           rd   - read data, combinational from registered state
//           gpi  - asynchronous inputs, channel i at [i*WIDTH +: WIDTH]
//           gpo  - registered outputs, same packing
//           irq  - registered level interrupt
// ---------------------------------------------------------------------------
module gpio_mmio
    import gpio_mmio_pkg::*;
#(
    parameter int          N_IN        = 2,
    parameter int          N_OUT       = 2,
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] GPO_RESET   = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel,
    input  logic                   we,
    input  logic [7:0]             addr,
    input  logic [31:0]            wd,
    output logic [31:0]            rd,
    input  logic [N_IN*WIDTH-1:0]  gpi,
    output logic [N_OUT*WIDTH-1:0] gpo,
    output logic                   irq
);

    localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

    logic                  wr;
    logic [2:0]            region;
    logic [2:0]            chan;
    logic                  is_status;
    logic                  is_irq_en;
    logic [N_IN*WIDTH-1:0] gpi_s;
    logic [N_IN*WIDTH-1:0] prev;
    logic [N_IN-1:0]       chg;
    logic [N_IN-1:0]       status;
    logic [N_IN-1:0]       irq_en;
    logic [N_IN-1:0]       w1c_mask;
    logic [2:0]            arm_cnt;
    logic                  armed;
    logic                  unused_bits;

    assign wr        = sel & we;
    assign region    = region_of(addr);
    assign chan      = chan_of(addr);
    assign is_status = (addr[7:2] == STATUS[7:2]);
    assign is_irq_en = (addr[7:2] == IRQ_EN[7:2]);

    // The byte-lane bits and any data bits beyond the channel width carry
    // no meaning for this block.
    assign unused_bits = ^{addr[1:0], wd};

    for (genvar i = 0; i < N_IN; i++) begin : g_sync
        gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (gpi[i*WIDTH +: WIDTH]),
            .q   (gpi_s[i*WIDTH +: WIDTH])
        );
    end

    // After reset release, the synchronisers flush their zeros out and let
    // the real pin values through. The resulting edge is not a genuine pin
    // change, so change detection stays disarmed until that flush is over.
    assign armed = (arm_cnt == ARM_COUNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= '0;
        else      prev <= gpi_s;
    end

    always_comb begin
        chg = '0;
        for (int i = 0; i < N_IN; i++)
            chg[i] = armed && (gpi_s[i*WIDTH +: WIDTH] != prev[i*WIDTH +: WIDTH]);
    end

    // A new change is OR-ed in after the clear mask is applied. If a change
    // and a clear hit the same bit in one cycle, the bit ends up set and the
    // event is not lost.
    assign w1c_mask = (wr && is_status) ? wd[N_IN-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) status <= '0;
        else      status <= chg | (status & ~w1c_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   irq_en <= '0;
        else if (wr && is_irq_en)   irq_en <= wd[N_IN-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else      irq <= |(status & irq_en);
    end

    // Only one address is presented per cycle, so write, set and clear
    // never collide on the same output channel.
    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        logic             hit;
        logic [WIDTH-1:0] gpo_q;

        assign hit = wr && (chan == 3'(o));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                gpo_q <= GPO_RESET[WIDTH-1:0];
            end else if (hit) begin
                if (region == region_of(GPO_BASE))      gpo_q <= wd[WIDTH-1:0];
                else if (region == region_of(SET_BASE)) gpo_q <= gpo_q | wd[WIDTH-1:0];
                else if (region == region_of(CLR_BASE)) gpo_q <= gpo_q & ~wd[WIDTH-1:0];
            end
        end

        assign gpo[o*WIDTH +: WIDTH] = gpo_q;
    end

    // Reads of the set and clear aliases return the output register. Reads
    // of unpopulated channels and unmapped addresses return zero.
    always_comb begin
        rd = '0;
        if (is_status) begin
            rd[N_IN-1:0] = status;
        end else if (is_irq_en) begin
            rd[N_IN-1:0] = irq_en;
        end else if (region == region_of(GPI_BASE)) begin
            for (int i = 0; i < N_IN; i++)
                if (chan == 3'(i)) rd[WIDTH-1:0] = gpi_s[i*WIDTH +: WIDTH];
        end else if (region == region_of(GPO_BASE) || region == region_of(SET_BASE) ||
                     region == region_of(CLR_BASE)) begin
            for (int o = 0; o < N_OUT; o++)
                if (chan == 3'(o)) rd[WIDTH-1:0] = gpo[o*WIDTH +: WIDTH];
        end
    end

endmodule
